// File: rtl/note_detect.sv
// Note detector: hysteretic rising-zero-crossing period measurement,
// period averaging and a sequential threshold search to a note id.
module note_detect #(
    parameter int unsigned CLK_FREQ      = 120_000_000,
    parameter int unsigned AM_WIDTH      = 8,
    parameter int unsigned HYST          = 4,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned TIMEOUT       = CLK_FREQ / 20,
    parameter int unsigned NOTE_COUNT    = 88,
    parameter int unsigned NOTEID_OFFSET = 1,
    parameter logic [32*NOTE_COUNT-1:0] NOTE_BOUNDS = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic signed [AM_WIDTH-1:0] am,
    output logic [31:0]                period,
    output logic [7:0]                 noteid,
    output logic                       valid,
    output logic                       changed,
    output logic                       busy
);

    localparam int unsigned IW = (NOTE_COUNT > 1) ? $clog2(NOTE_COUNT) : 1;
    localparam int unsigned CW = AVG_LOG2 + 1;
    localparam int unsigned AW = 32 + AVG_LOG2;
    localparam logic signed [AM_WIDTH-1:0] HPOS = AM_WIDTH'(HYST);
    localparam logic signed [AM_WIDTH-1:0] HNEG = -HPOS;
    localparam logic [CW-1:0] NLAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [IW-1:0] ILAST = IW'(NOTE_COUNT - 1);
    localparam logic [31:0]   TMO   = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic            first_q, first_d;
    logic            pend_q, pend_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     pavg_q, pavg_d;
    logic [31:0]     savg_q, savg_d;
    logic [31:0]     period_q, period_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   ncap_q, ncap_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      res_q, res_d;
    logic [7:0]      noteid_q, noteid_d;
    logic            valid_q, valid_d;
    logic            changed_q, changed_d;
    logic            busy_q, busy_d;
    logic            rise, silence, take;
    logic [AW-1:0]   sum;
    logic [31:0]     bound;

    assign rise    = sample_en && armed_q && (am >= HPOS);
    // One-shot: first is set on entry, so a saturated counter fires once.
    assign silence = !rise && !first_q && (cnt_q == TMO);
    assign take    = (state_q == IDLE) && pend_q;
    assign sum     = acc_q + AW'(cnt_q);

    always_comb begin
        armed_d = armed_q;
        if (sample_en) begin
            if (am <= HNEG) begin
                armed_d = 1'b1;
            end else if (rise) begin
                armed_d = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d   = (cnt_q == TMO) ? cnt_q : cnt_q + 32'd1;
        first_d = first_q;
        acc_d   = acc_q;
        ncap_d  = ncap_q;
        pend_d  = pend_q && !take;
        pavg_d  = pavg_q;
        if (rise) begin
            cnt_d = 32'd1;
            if (first_q) begin
                first_d = 1'b0;
            end else if (ncap_q == NLAST) begin
                pavg_d = sum[AVG_LOG2 +: 32];
                pend_d = 1'b1;
                acc_d  = '0;
                ncap_d = '0;
            end else begin
                acc_d  = sum;
                ncap_d = ncap_q + CW'(1);
            end
        end else if (silence) begin
            first_d = 1'b1;
            acc_d   = '0;
            ncap_d  = '0;
            pend_d  = 1'b0;
        end
    end

    always_comb begin
        bound = '0;
        for (int j = 0; j < NOTE_COUNT; j++) begin
            if (idx_q == IW'(j)) begin
                bound = NOTE_BOUNDS[32*j +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        savg_d    = savg_q;
        res_d     = res_q;
        period_d  = period_q;
        noteid_d  = noteid_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    savg_d  = pavg_q;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (savg_q >= bound) begin
                    res_d   = 8'(NOTEID_OFFSET) + 8'(idx_q);
                    state_d = DONE;
                end else if (idx_q == ILAST) begin
                    res_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                period_d  = savg_q;
                noteid_d  = res_q;
                valid_d   = 1'b1;
                changed_d = (res_q != noteid_q);
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Silence aborts any search and reports only a real change.
        if (silence) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            period_d  = period_q;
            noteid_d  = noteid_q;
            valid_d   = 1'b0;
            changed_d = 1'b0;
            if (noteid_q != 8'd0) begin
                period_d  = '0;
                noteid_d  = 8'd0;
                valid_d   = 1'b1;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            first_q   <= 1'b1;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            pavg_q    <= '0;
            savg_q    <= '0;
            period_q  <= '0;
            acc_q     <= '0;
            ncap_q    <= '0;
            idx_q     <= '0;
            res_q     <= '0;
            noteid_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            first_q   <= first_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            pavg_q    <= pavg_d;
            savg_q    <= savg_d;
            period_q  <= period_d;
            acc_q     <= acc_d;
            ncap_q    <= ncap_d;
            idx_q     <= idx_d;
            res_q     <= res_d;
            noteid_q  <= noteid_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign period  = period_q;
    assign noteid  = noteid_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign busy    = busy_q;

endmodule
